// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..DATA_W data bits, none/even/odd parity, 1 or 2 stop bits.
// A one-entry holding register lets the next frame start right after the current one ends.
module uart_tx_cfg #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CNT_W-1:0]  cfg_data_len,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              tx_line,
  output logic              tx_busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    if (len < CNT_W'(5))
      return CNT_W'(5);
    if (len > CNT_W'(DATA_W))
      return CNT_W'(DATA_W);
    return len;
  endfunction

  function automatic logic parity_of(input logic [DATA_W-1:0] data,
                                     input logic [CNT_W-1:0]  len,
                                     input logic              odd);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < DATA_W; i++)
      mask[i] = (i < int'(len));
    return (^(data & mask)) ^ odd;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               hold_full;

  logic [DATA_W-1:0]  hold_data;
  logic [CNT_W-1:0]   hold_len;
  logic               hold_par_en;
  logic               hold_par;
  logic               hold_stop2;

  logic [DATA_W-1:0]  shift;
  logic [CNT_W-1:0]   f_len;
  logic               f_par_en;
  logic               f_par;
  logic               f_stop2;

  logic               accept;
  logic               frame_end;
  logic               load;
  logic               shift_en;

  always_comb begin
    accept    = tx_valid && !hold_full;
    frame_end = tick && ((state == STOP1 && !f_stop2) || state == STOP2);
    load      = hold_full && ((tick && state == IDLE) || frame_end);
    shift_en  = tick && (state == START || (state == DATA && cnt != f_len));
  end

  assign tx_ready = !hold_full;
  assign tx_busy  = (state != IDLE) || hold_full;

  // Control: state, bit counter, hold occupancy and the line itself
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_full <= 1'b0;
      tx_line   <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (accept)
        hold_full <= 1'b1;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (hold_full) begin
              tx_line   <= 1'b0;
              hold_full <= 1'b0;
              state     <= START;
            end
          end
          START: begin
            tx_line <= shift[0];
            cnt     <= CNT_W'(1);
            state   <= DATA;
          end
          DATA: begin
            if (cnt == f_len) begin
              if (f_par_en) begin
                tx_line <= f_par;
                state   <= PARITY;
              end else begin
                tx_line <= 1'b1;
                state   <= STOP1;
              end
            end else begin
              tx_line <= shift[0];
              cnt     <= cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            tx_line <= 1'b1;
            state   <= STOP1;
          end
          STOP1: begin
            if (f_stop2)
              state <= STOP2;
          end
          STOP2: ;
          default: state <= IDLE;
        endcase
      end
      // Last stop bit done: chain straight into the queued frame if there is one
      if (frame_end) begin
        tx_done <= 1'b1;
        cnt     <= '0;
        if (hold_full) begin
          tx_line   <= 1'b0;
          hold_full <= 1'b0;
          state     <= START;
        end else begin
          tx_line <= 1'b1;
          state   <= IDLE;
        end
      end
    end
  end

  // Datapath: captured payload/config and the output shifter
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data   <= tx_data;
      hold_len    <= clamp_len(cfg_data_len);
      hold_par_en <= cfg_parity[0] ^ cfg_parity[1];
      hold_par    <= parity_of(tx_data, clamp_len(cfg_data_len), cfg_parity[1]);
      hold_stop2  <= cfg_stop2;
    end
    if (load) begin
      shift    <= hold_data;
      f_len    <= hold_len;
      f_par_en <= hold_par_en;
      f_par    <= hold_par;
      f_stop2  <= hold_stop2;
    end else if (shift_en) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues hand-written line sequences per frame,
// a monitor compares tx_line/tx_done at every baud tick edge.
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       tx_valid;
  logic       tx_ready;
  logic [8:0] tx_data;
  logic [3:0] cfg_data_len;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx_line;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_cfg #(.DATA_W(9), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .cfg_data_len(cfg_data_len), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  typedef struct packed {
    logic line;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   tcnt      = 0;
  int   frame_no  = 0;
  bit   mon_en    = 1'b1;
  bit   mon_active = 1'b0;
  bit   mon_pend   = 1'b0;
  logic mon_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick every 4th clock, driven away from the active edge
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      tick = (tcnt % 4 == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %0d expected %0d (frame %0d, t=%0t)", nm, act, exp, frame_no, $time);
  endtask

  task automatic push_str(input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.line = (s.getc(i) == "1");
      e.last = (i == s.len() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [8:0] d, input logic [3:0] l, input logic [1:0] p,
                      input logic s2, input string exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready wait", tx_ready, 1);
    if (exp.len() > 0)
      push_str(exp);
    tx_valid     = 1'b1;
    tx_data      = d;
    cfg_data_len = l;
    cfg_parity   = p;
    cfg_stop2    = s2;
    @(negedge clk);
    tx_valid     = 1'b0;
    tx_data      = 9'($urandom);
    cfg_data_len = 4'($urandom);
    cfg_parity   = 2'($urandom);
    cfg_stop2    = 1'($urandom);
    chk("ready low after accept", tx_ready, 0);
    chk("busy after accept", tx_busy, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle timeout", tx_busy, 0);
    repeat (8) @(negedge clk);
    frame_no++;
  endtask

  // Monitor: one expected line value per tick edge while a frame is on the line
  initial begin
    exp_t e;
    bit   had_pend;
    forever begin
      @(posedge clk);
      mon_t = tick;
      #1;
      if (!mon_en || !rst) begin
        mon_active = 1'b0;
        mon_pend   = 1'b0;
      end else if (mon_t) begin
        had_pend = mon_pend;
        if (mon_pend) begin
          chk("tx_done at frame end", tx_done, 1);
          mon_pend = 1'b0;
        end
        if (!mon_active && tx_line == 1'b0) begin
          if (exp_q.size() == 0)
            chk("spurious start bit", tx_line, 1);
          else
            mon_active = 1'b1;
        end
        if (mon_active) begin
          e = exp_q.pop_front();
          chk("tx_line", tx_line, e.line);
          if (!had_pend)
            chk("no early tx_done", tx_done, 0);
          if (e.last) begin
            mon_active = 1'b0;
            mon_pend   = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int viol;
    rst          = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = '0;
    cfg_data_len = 4'd8;
    cfg_parity   = 2'b00;
    cfg_stop2    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx_line", tx_line, 1);
    chk("reset tx_ready", tx_ready, 1);
    chk("reset tx_busy", tx_busy, 0);
    chk("reset tx_done", tx_done, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    send(9'h0A5, 4'd8, 2'b00, 1'b0, "0101001011");
    wait_idle();
    // 7 bits even / odd parity on 0x53
    send(9'h053, 4'd7, 2'b01, 1'b0, "0110010101");
    wait_idle();
    send(9'h053, 4'd7, 2'b10, 1'b0, "0110010111");
    wait_idle();
    // 9 bits, odd parity, two stop bits
    send(9'h1FF, 4'd9, 2'b10, 1'b1, "0111111111011");
    wait_idle();
    // Back-to-back: second frame queued while the first is in its data bits
    send(9'h055, 4'd8, 2'b00, 1'b0, "0101010101");
    repeat (20) @(negedge clk);
    send(9'h00F, 4'd8, 2'b00, 1'b0, "0111100001");
    wait_idle();
    // Length clamping and parity masking
    send(9'h0FF, 4'd3, 2'b00, 1'b0, "0111111");
    wait_idle();
    send(9'h155, 4'd12, 2'b01, 1'b0, "010101010111");
    wait_idle();
    send(9'h0F1, 4'd5, 2'b01, 1'b0, "01000101");
    wait_idle();
    chk("scoreboard drained", exp_q.size(), 0);

    // Reset mid-frame with a second byte queued
    mon_en = 1'b0;
    send(9'h03C, 4'd8, 2'b00, 1'b0, "");
    repeat (24) @(negedge clk);
    send(9'h081, 4'd8, 2'b00, 1'b0, "");
    #2;
    rst = 1'b0;
    #1;
    chk("reset mid-frame tx_line", tx_line, 1);
    chk("reset mid-frame tx_busy", tx_busy, 0);
    chk("reset mid-frame tx_ready", tx_ready, 1);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    viol = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (tx_line !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0)
        viol++;
    end
    chk("no residual frame after reset", viol, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
